// File: rtl/pipe_hazard_unit.sv
// ---------------------------------------------------------------------------
// pipe_hazard_unit
//
// Hazard detection and operand-bypass control for an in-order pipeline with
// DEPTH tracked stages after decode (stage 0 = X ... stage DEPTH-1 = W).
// A small scoreboard records, per stage, whether the instruction there will
// write a register, which register it writes, and whether it is a load.
// Decode sources are matched against the scoreboard to pick the youngest
// forwarding stage. The unit raises stall for load-use hazards and while a
// multi-cycle long op occupies X, and raises flush for taken branches.
//
// Parameters
//   REG_W     register-index width
//   DEPTH     tracked stages after decode (2..8)
//   LONG_LAT  total cycles a long op occupies X (2..255)
//
// Ports
//   clock, reset             single clock; synchronous active-high reset
//   dec_valid                decode holds a real instruction
//   dec_rs_a/b, dec_use_a/b  source indices and "source is read" flags
//   dec_rd, dec_wr           destination index and write enable
//   dec_is_load, dec_is_long instruction class
//   br_taken                 taken branch/jump resolved in X this cycle
//   stall                    hold PC and F/D latch
//   flush                    kill F/D contents
//   issue                    decode instruction enters X this cycle
//   byp_a_sel, byp_b_sel     0 = regfile, i+1 = result from stage i
//   long_busy                long op executing in X
// ---------------------------------------------------------------------------
module pipe_hazard_unit #(
  parameter int REG_W    = 5,
  parameter int DEPTH    = 3,
  parameter int LONG_LAT = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       dec_valid,
  input  logic [REG_W-1:0]           dec_rs_a,
  input  logic [REG_W-1:0]           dec_rs_b,
  input  logic                       dec_use_a,
  input  logic                       dec_use_b,
  input  logic [REG_W-1:0]           dec_rd,
  input  logic                       dec_wr,
  input  logic                       dec_is_load,
  input  logic                       dec_is_long,
  input  logic                       br_taken,
  output logic                       stall,
  output logic                       flush,
  output logic                       issue,
  output logic [$clog2(DEPTH+1)-1:0] byp_a_sel,
  output logic [$clog2(DEPTH+1)-1:0] byp_b_sel,
  output logic                       long_busy
);

  localparam int SEL_W = $clog2(DEPTH+1);
  // Counter only ever holds LONG_LAT-1 down to 0.
  localparam int CNT_W = (LONG_LAT > 2) ? $clog2(LONG_LAT) : 1;

  // Scoreboard state.
  logic [DEPTH-1:0] v_q, v_d;
  logic [DEPTH-1:0] ld_q, ld_d;
  logic [REG_W-1:0] rd_q [DEPTH];
  logic [REG_W-1:0] rd_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic load_use;

  assign long_busy = (cnt_q != '0);

  // Operand bypass select: scan from the oldest stage down so the youngest
  // (smallest index) matching writer wins. Register 0 never forwards.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    byp_a_sel = '0;
    byp_b_sel = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (dec_use_a && (dec_rs_a != '0) && v_q[i] && (rd_q[i] == dec_rs_a))
        byp_a_sel = SEL_W'(i + 1);
      if (dec_use_b && (dec_rs_b != '0) && v_q[i] && (rd_q[i] == dec_rs_b))
        byp_b_sel = SEL_W'(i + 1);
    end
  end

  // A load still in X has no data yet; the dependent must wait one cycle.
  assign load_use = ld_q[0] &&
                    ((byp_a_sel == SEL_W'(1)) || (byp_b_sel == SEL_W'(1)));

  // Priority: long_busy > flush > load_use.
  assign stall = dec_valid & (long_busy | (load_use & ~br_taken));
  assign flush = br_taken & ~long_busy;
  assign issue = dec_valid & ~stall & ~flush;

  // Next-state for scoreboard and long-op counter.
  always_comb begin
    v_d   = v_q;
    ld_d  = ld_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;

    // Stages 2..DEPTH-1 always advance; the oldest entry falls off.
    for (int i = DEPTH-1; i >= 2; i--) begin
      v_d[i]  = v_q[i-1];
      ld_d[i] = ld_q[i-1];
      rd_d[i] = rd_q[i-1];
    end

    if (long_busy) begin
      // Long op holds X; a bubble opens behind it in stage 1.
      v_d[1]  = 1'b0;
      ld_d[1] = 1'b0;
      rd_d[1] = '0;
      cnt_d   = cnt_q - CNT_W'(1);
    end else begin
      v_d[1]  = v_q[0];
      ld_d[1] = ld_q[0];
      rd_d[1] = rd_q[0];
      if (issue) begin
        v_d[0]  = dec_wr && (dec_rd != '0);
        ld_d[0] = dec_is_load;
        rd_d[0] = dec_rd;
        if (dec_is_long)
          cnt_d = CNT_W'(LONG_LAT - 1);
      end else begin
        v_d[0]  = 1'b0;
        ld_d[0] = 1'b0;
        rd_d[0] = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      v_q   <= '0;
      ld_q  <= '0;
      cnt_q <= '0;
      // NOTE: rd_q is a small flop array, not RAM, so it is cleared too and
      // never carries stale indices out of reset.
      for (int i = 0; i < DEPTH; i++)
        rd_q[i] <= '0;
    end else begin
      v_q   <= v_d;
      ld_q  <= ld_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_unit
//
// Directed vectors for pipe_hazard_unit (DEPTH=3, LONG_LAT=4). The driver
// applies one decode vector per cycle and pushes the hand-computed expected
// outputs into a queue; a monitor pops on the falling edge and compares.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_unit;

  localparam int REG_W    = 5;
  localparam int DEPTH    = 3;
  localparam int LONG_LAT = 4;
  localparam int SEL_W    = $clog2(DEPTH+1);

  logic             clock = 1'b0;
  logic             reset;
  logic             dec_valid;
  logic [REG_W-1:0] dec_rs_a, dec_rs_b, dec_rd;
  logic             dec_use_a, dec_use_b, dec_wr, dec_is_load, dec_is_long;
  logic             br_taken;
  logic             stall, flush, issue, long_busy;
  logic [SEL_W-1:0] byp_a_sel, byp_b_sel;

  typedef struct {
    string            name;
    logic             stall;
    logic             flush;
    logic             issue;
    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;
    logic             busy;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  pipe_hazard_unit #(.REG_W(REG_W), .DEPTH(DEPTH), .LONG_LAT(LONG_LAT)) dut (
    .clock      (clock),
    .reset      (reset),
    .dec_valid  (dec_valid),
    .dec_rs_a   (dec_rs_a),
    .dec_rs_b   (dec_rs_b),
    .dec_use_a  (dec_use_a),
    .dec_use_b  (dec_use_b),
    .dec_rd     (dec_rd),
    .dec_wr     (dec_wr),
    .dec_is_load(dec_is_load),
    .dec_is_long(dec_is_long),
    .br_taken   (br_taken),
    .stall      (stall),
    .flush      (flush),
    .issue      (issue),
    .byp_a_sel  (byp_a_sel),
    .byp_b_sel  (byp_b_sel),
    .long_busy  (long_busy)
  );

  task automatic check(input string name, input string field,
                       input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s.%s: got %0d, expected %0d", name, field, got, want);
    end
  endtask

  // Monitor: compares whatever the driver expected for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.name, "stall",     int'(stall),     int'(e.stall));
        check(e.name, "flush",     int'(flush),     int'(e.flush));
        check(e.name, "issue",     int'(issue),     int'(e.issue));
        check(e.name, "byp_a_sel", int'(byp_a_sel), int'(e.sel_a));
        check(e.name, "byp_b_sel", int'(byp_b_sel), int'(e.sel_b));
        check(e.name, "long_busy", int'(long_busy), int'(e.busy));
      end
    end
  end

  // One cycle of stimulus plus its expected outputs.
  task automatic cyc(input string nm, input logic rst,
                     input logic v, input logic [4:0] ra, input logic ua,
                     input logic [4:0] rb, input logic ub,
                     input logic [4:0] rd, input logic wr, input logic ld,
                     input logic lg, input logic br,
                     input logic es, input logic ef, input logic ei,
                     input int esa, input int esb, input logic elb);
    exp_t e;
    @(posedge clock);
    #1;
    reset       = rst;
    dec_valid   = v;
    dec_rs_a    = ra;
    dec_use_a   = ua;
    dec_rs_b    = rb;
    dec_use_b   = ub;
    dec_rd      = rd;
    dec_wr      = wr;
    dec_is_load = ld;
    dec_is_long = lg;
    br_taken    = br;
    e.name  = nm;
    e.stall = es;
    e.flush = ef;
    e.issue = ei;
    e.sel_a = SEL_W'(esa);
    e.sel_b = SEL_W'(esb);
    e.busy  = elb;
    exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b1; dec_valid = 1'b0; dec_rs_a = '0; dec_rs_b = '0;
    dec_use_a = 1'b0; dec_use_b = 1'b0; dec_rd = '0; dec_wr = 1'b0;
    dec_is_load = 1'b0; dec_is_long = 1'b0; br_taken = 1'b0;
    repeat (2) @(posedge clock);

    //   name        rst v  ra ua rb ub rd wr ld lg br | st fl is sa sb lb
    cyc("rst_br",    1, 1,  0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0, 0);
    cyc("alu_x3",    0, 1,  0, 0, 0, 0, 3, 1, 0, 0, 0,  0, 0, 1, 0, 0, 0);
    cyc("dep_x3_s0", 0, 1,  3, 1, 0, 0, 4, 1, 0, 0, 0,  0, 0, 1, 1, 0, 0);
    cyc("dep_x3_s1", 0, 1,  3, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 2, 0, 0);
    cyc("dep_x3_s2", 0, 1,  3, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 3, 0, 0);
    cyc("x3_gone",   0, 1,  3, 1, 4, 1, 0, 0, 0, 0, 0,  0, 0, 1, 0, 3, 0);
    cyc("load_x5",   0, 1,  0, 0, 0, 0, 5, 1, 1, 0, 0,  0, 0, 1, 0, 0, 0);
    cyc("ld_use",    0, 1,  0, 0, 5, 1, 6, 1, 0, 0, 0,  1, 0, 0, 0, 1, 0);
    cyc("ld_use_ok", 0, 1,  0, 0, 5, 1, 6, 1, 0, 0, 0,  0, 0, 1, 0, 2, 0);
    cyc("long_x7",   0, 1,  5, 1, 6, 1, 7, 1, 0, 1, 0,  0, 0, 1, 3, 1, 0);
    cyc("long_b1",   0, 1,  7, 1, 6, 1, 8, 1, 0, 0, 0,  1, 0, 0, 1, 2, 1);
    cyc("long_b2",   0, 1,  7, 1, 6, 1, 8, 1, 0, 0, 0,  1, 0, 0, 1, 3, 1);
    cyc("long_b3br", 0, 1,  7, 1, 6, 1, 8, 1, 0, 0, 1,  1, 0, 0, 1, 0, 1);
    cyc("long_done", 0, 1,  7, 1, 6, 1, 8, 1, 0, 0, 0,  0, 0, 1, 1, 0, 0);
    cyc("branch",    0, 1,  7, 1, 0, 0, 9, 1, 0, 0, 1,  0, 1, 0, 2, 0, 0);
    cyc("post_br",   0, 1,  8, 1, 9, 1, 0, 1, 0, 0, 0,  0, 0, 1, 2, 0, 0);
    cyc("load_x0",   0, 1,  8, 1, 0, 0, 0, 1, 1, 0, 0,  0, 0, 1, 3, 0, 0);
    cyc("read_x0",   0, 1,  0, 1, 0, 1,10, 1, 0, 1, 0,  0, 0, 1, 0, 0, 0);
    cyc("busy_idle", 0, 0, 10, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 1);
    cyc("rst_mid",   1, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 1);
    cyc("rst_held",  1, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0);
    cyc("post_rst",  0, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0);
    cyc("long_a",    0, 1,  0, 0, 0, 0,11, 1, 0, 1, 0,  0, 0, 1, 0, 0, 0);
    cyc("long_b_w1", 0, 1,  0, 0, 0, 0,12, 1, 0, 1, 0,  1, 0, 0, 0, 0, 1);
    cyc("long_b_w2", 0, 1,  0, 0, 0, 0,12, 1, 0, 1, 0,  1, 0, 0, 0, 0, 1);
    cyc("long_b_w3", 0, 1,  0, 0, 0, 0,12, 1, 0, 1, 0,  1, 0, 0, 0, 0, 1);
    cyc("long_b",    0, 1,  0, 0, 0, 0,12, 1, 0, 1, 0,  0, 0, 1, 0, 0, 0);
    cyc("b2b_fwd1",  0, 0, 11, 1,12, 1, 0, 0, 0, 0, 0,  0, 0, 0, 2, 1, 1);
    cyc("b2b_fwd2",  0, 0, 11, 1,12, 1, 0, 0, 0, 0, 0,  0, 0, 0, 3, 1, 1);

    @(posedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
